seletor_mapa_ciclico: RTL and testbench



---
 rtl/seletor_mapa_ciclico_if.sv | 40 ++++
 rtl/seletor_mapa_ciclico.sv | 104 ++++++++++
 tb/tb_seletor_mapa_ciclico.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seletor_mapa_ciclico_if.sv
// Bus grouping for seletor_mapa_ciclico.
//   master : the side that supplies maps and controls (testbench, game logic)
//   slave  : the selector itself
// Signals:
//   mapas    flattened maps, map k at [k*LARGURA +: LARGURA], map 0 in the LSBs
//   sel      index loaded when carregar=1
//   carregar load pulse for sel (honoured in both modes)
//   modo     0 = manual, 1 = auto-rotate
//   pausa    freezes the period counter in auto mode
//   out      registered selected map
//   indice   registered current index
//   virou    one-cycle pulse after an auto advance wraps NUM_MAPAS-1 -> 0
//   estado   debug view of the mode register (0 = MANUAL, 1 = AUTO)
// There is no valid/ready handshake on this bus: every control input is
// sampled on each rising clock edge and every output is a plain register.
interface seletor_mapa_ciclico_if #(
    parameter int LARGURA   = 7,
    parameter int NUM_MAPAS = 8,
    parameter int SEL_W     = 3
);
    logic [NUM_MAPAS*LARGURA-1:0] mapas;
    logic [SEL_W-1:0]             sel;
    logic                         carregar;
    logic                         modo;
    logic                         pausa;
    logic [LARGURA-1:0]           out;
    logic [SEL_W-1:0]             indice;
    logic                         virou;
    logic                         estado;

    modport master (
        output mapas, sel, carregar, modo, pausa,
        input  out, indice, virou, estado
    );

    modport slave (
        input  mapas, sel, carregar, modo, pausa,
        output out, indice, virou, estado
    );
endinterface

// File: rtl/seletor_mapa_ciclico.sv
// Registered map selector with manual and auto-rotate modes.
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high reset (priority over everything)
//   bus    seletor_mapa_ciclico_if slave modport (maps, controls, outputs)
// Behaviour summary:
//   - A load (carregar) with an in-range sel moves the index there; an
//     out-of-range sel is ignored but still restarts the period counter.
//   - In AUTO, the index advances once every PERIODO unpaused cycles,
//     wrapping NUM_MAPAS-1 -> 0 and pulsing virou for one cycle.
//   - out is always the map selected by the index registered with it.
module seletor_mapa_ciclico #(
    parameter int LARGURA   = 7,
    parameter int NUM_MAPAS = 8,
    parameter int SEL_W     = 3,
    parameter int PERIODO   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    seletor_mapa_ciclico_if.slave  bus
);

    localparam int CNT_W = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(PERIODO - 1);
    // One extra bit so NUM_MAPAS == 2**SEL_W is still representable.
    localparam logic [SEL_W:0]   LIMITE  = (SEL_W + 1)'(NUM_MAPAS);
    localparam logic [SEL_W-1:0] ULTIMO  = SEL_W'(NUM_MAPAS - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } estado_t;

    estado_t            estado;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [SEL_W-1:0]   indice_r;
    logic [SEL_W-1:0]   indice_next;
    logic [LARGURA-1:0] out_r;
    logic [LARGURA-1:0] out_next;
    logic               virou_r;
    logic               virou_next;
    logic               carga_valida;
    logic               avanca;
    logic               troca_modo;

    always_comb begin
        carga_valida = bus.carregar && ({1'b0, bus.sel} < LIMITE);
        // A load in the same cycle suppresses the advance: the load wins.
        avanca       = !bus.carregar && (estado == AUTO) && !bus.pausa &&
                       (cnt == CNT_FIM);
        troca_modo   = bus.modo != (estado == AUTO);

        indice_next = indice_r;
        virou_next  = 1'b0;
        if (carga_valida) begin
            indice_next = bus.sel;
        end else if (avanca) begin
            if (indice_r == ULTIMO) begin
                indice_next = '0;
                virou_next  = 1'b1;
            end else begin
                indice_next = indice_r + SEL_W'(1);
            end
        end

        cnt_next = cnt;
        if (bus.carregar || troca_modo || (estado == MANUAL) || avanca) begin
            cnt_next = '0;
        end else if (!bus.pausa) begin
            cnt_next = cnt + CNT_W'(1);
        end

        // Select from the next index so out and indice always agree.
        out_next = '0;
        for (int k = 0; k < NUM_MAPAS; k++) begin
            if (indice_next == SEL_W'(k)) begin
                out_next = bus.mapas[k*LARGURA +: LARGURA];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= MANUAL;
            cnt      <= '0;
            indice_r <= '0;
            out_r    <= '0;
            virou_r  <= 1'b0;
        end else begin
            estado   <= bus.modo ? AUTO : MANUAL;
            cnt      <= cnt_next;
            indice_r <= indice_next;
            out_r    <= out_next;
            virou_r  <= virou_next;
        end
    end

    assign bus.out    = out_r;
    assign bus.indice = indice_r;
    assign bus.virou  = virou_r;
    assign bus.estado = estado;

endmodule

// File: tb/tb_seletor_mapa_ciclico.sv
// Testbench for seletor_mapa_ciclico: three instances sharing one control
// set (8 maps / period 4, 6 maps / period 3, 2 maps / period 1), each
// checked every cycle against a cycle-level reference model, plus directed
// checks against hand-derived constants.
module tb_seletor_mapa_ciclico;

    localparam int L = 7;

    logic clk;
    logic reset;

    seletor_mapa_ciclico_if #(.LARGURA(L), .NUM_MAPAS(8), .SEL_W(3)) if8 ();
    seletor_mapa_ciclico_if #(.LARGURA(L), .NUM_MAPAS(6), .SEL_W(3)) if6 ();
    seletor_mapa_ciclico_if #(.LARGURA(L), .NUM_MAPAS(2), .SEL_W(3)) if2 ();

    seletor_mapa_ciclico #(.LARGURA(L), .NUM_MAPAS(8), .SEL_W(3), .PERIODO(4)) u8 (
        .clk(clk), .reset(reset), .bus(if8.slave));
    seletor_mapa_ciclico #(.LARGURA(L), .NUM_MAPAS(6), .SEL_W(3), .PERIODO(3)) u6 (
        .clk(clk), .reset(reset), .bus(if6.slave));
    seletor_mapa_ciclico #(.LARGURA(L), .NUM_MAPAS(2), .SEL_W(3), .PERIODO(1)) u2 (
        .clk(clk), .reset(reset), .bus(if2.slave));

    // Shared stimulus
    logic [2:0]   sel;
    logic         carregar;
    logic         modo;
    logic         pausa;
    logic [L-1:0] maps [8];

    assign if8.sel = sel;  assign if8.carregar = carregar;
    assign if8.modo = modo; assign if8.pausa = pausa;
    assign if6.sel = sel;  assign if6.carregar = carregar;
    assign if6.modo = modo; assign if6.pausa = pausa;
    assign if2.sel = sel;  assign if2.carregar = carregar;
    assign if2.modo = modo; assign if2.pausa = pausa;

    always_comb begin
        for (int k = 0; k < 8; k++) if8.mapas[k*L +: L] = maps[k];
        for (int k = 0; k < 6; k++) if6.mapas[k*L +: L] = maps[k];
        for (int k = 0; k < 2; k++) if2.mapas[k*L +: L] = maps[k];
    end

    // Observed outputs gathered per instance
    logic [2:0]   ind_o [3];
    logic [L-1:0] out_o [3];
    logic         vir_o [3];
    logic         est_o [3];
    assign ind_o[0] = if8.indice; assign out_o[0] = if8.out;
    assign vir_o[0] = if8.virou;  assign est_o[0] = if8.estado;
    assign ind_o[1] = if6.indice; assign out_o[1] = if6.out;
    assign vir_o[1] = if6.virou;  assign est_o[1] = if6.estado;
    assign ind_o[2] = if2.indice; assign out_o[2] = if2.out;
    assign vir_o[2] = if2.virou;  assign est_o[2] = if2.estado;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1);
    end

    // Reference model: index plus count of unpaused cycles since the last
    // restart; an advance happens when that count reaches the period.
    int           n_m [3] = '{8, 6, 2};
    int           p_m [3] = '{4, 3, 1};
    int           idx_m   [3];
    int           ticks_m [3];
    bit           auto_m  [3];
    bit           vir_m   [3];
    logic [L-1:0] out_m   [3];

    int vetores;
    int erros;

    task automatic modelo_borda();
        bit adv;
        for (int m = 0; m < 3; m++) begin
            if (reset) begin
                idx_m[m]   = 0;
                ticks_m[m] = 0;
                auto_m[m]  = 1'b0;
                vir_m[m]   = 1'b0;
                out_m[m]   = '0;
            end else begin
                adv = auto_m[m] && !carregar && !pausa && (ticks_m[m] == p_m[m] - 1);
                vir_m[m] = 1'b0;
                if (carregar) begin
                    if (int'(sel) < n_m[m]) idx_m[m] = int'(sel);
                end else if (adv) begin
                    if (idx_m[m] == n_m[m] - 1) begin
                        idx_m[m] = 0;
                        vir_m[m] = 1'b1;
                    end else begin
                        idx_m[m] = idx_m[m] + 1;
                    end
                end
                if (carregar || (modo != auto_m[m]) || !auto_m[m] || adv)
                    ticks_m[m] = 0;
                else if (!pausa)
                    ticks_m[m] = ticks_m[m] + 1;
                auto_m[m] = modo;
                out_m[m]  = maps[idx_m[m]];
            end
        end
    endtask

    // Scoreboard comparison
    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vetores++;
        assert (obs === exp) else begin
            erros++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic confere_todos();
        for (int m = 0; m < 3; m++) begin
            verifica($sformatf("indice[%0d]", m), 32'(ind_o[m]), 32'(idx_m[m]));
            verifica($sformatf("out[%0d]", m),    32'(out_o[m]), 32'(out_m[m]));
            verifica($sformatf("virou[%0d]", m),  32'(vir_o[m]), 32'(vir_m[m]));
            verifica($sformatf("estado[%0d]", m), 32'(est_o[m]), 32'(auto_m[m]));
        end
    endtask

    // Driver: one clock edge, model update, then sample on the falling edge.
    task automatic ciclo();
        @(posedge clk);
        modelo_borda();
        @(negedge clk);
        confere_todos();
    endtask

    task automatic ciclos(input int n);
        for (int i = 0; i < n; i++) ciclo();
    endtask

    int idx6_antes;

    initial begin
        vetores  = 0;
        erros    = 0;
        reset    = 1'b1;
        sel      = '0;
        carregar = 1'b0;
        modo     = 1'b0;
        pausa    = 1'b0;
        maps[0] = 7'b1000001; maps[1] = 7'b1100011;
        maps[2] = 7'b1110111; maps[3] = 7'b1111001;
        maps[4] = 7'b1111101; maps[5] = 7'b1111110;
        maps[6] = 7'b1111111; maps[7] = 7'b0111111;
        @(negedge clk);

        // Reset
        ciclo();
        verifica("rst_out", 32'(if8.out), 32'(0));
        verifica("rst_indice", 32'(if8.indice), 32'(0));
        reset = 1'b0;

        // Manual load of map 3
        sel = 3'd3; carregar = 1'b1;
        ciclo();
        carregar = 1'b0;
        verifica("man_indice", 32'(if8.indice), 32'(3));
        verifica("man_out", 32'(if8.out), 32'(7'b1111001));

        // Auto rotation from index 6
        sel = 3'd6; carregar = 1'b1; modo = 1'b1;
        ciclo();
        carregar = 1'b0;
        ciclos(3);
        verifica("auto_hold6", 32'(if8.indice), 32'(6));
        ciclo();
        verifica("auto_idx7", 32'(if8.indice), 32'(7));
        verifica("auto_out7", 32'(if8.out), 32'(7'b0111111));
        ciclos(3);
        verifica("auto_nowrap_yet", 32'(if8.virou), 32'(0));
        ciclo();
        verifica("wrap_idx0", 32'(if8.indice), 32'(0));
        verifica("wrap_out0", 32'(if8.out), 32'(7'b1000001));
        verifica("wrap_virou", 32'(if8.virou), 32'(1));
        ciclo();
        verifica("wrap_virou_off", 32'(if8.virou), 32'(0));

        // Pause with counter at 2
        ciclo();
        pausa = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ciclo();
            verifica("pausa_hold", 32'(if8.indice), 32'(0));
        end
        pausa = 1'b0;
        ciclo();
        verifica("pausa_rel1", 32'(if8.indice), 32'(0));
        ciclo();
        verifica("pausa_rel2", 32'(if8.indice), 32'(1));

        // Load on the same edge the advance would happen
        ciclos(3);
        sel = 3'd5; carregar = 1'b1;
        ciclo();
        carregar = 1'b0;
        verifica("prio_idx", 32'(if8.indice), 32'(5));
        verifica("prio_out", 32'(if8.out), 32'(7'b1111110));
        verifica("prio_virou", 32'(if8.virou), 32'(0));
        ciclos(3);
        verifica("prio_hold", 32'(if8.indice), 32'(5));
        ciclo();
        verifica("prio_next", 32'(if8.indice), 32'(6));

        // Out-of-range load and live map update, in manual mode
        modo = 1'b0;
        ciclo();
        idx6_antes = idx_m[1];
        sel = 3'd7; carregar = 1'b1;
        ciclo();
        carregar = 1'b0;
        verifica("oor_idx6", 32'(if6.indice), 32'(idx6_antes));
        verifica("oor_idx8", 32'(if8.indice), 32'(7));
        maps[idx6_antes] = ~maps[idx6_antes];
        ciclo();
        verifica("live_out6", 32'(if6.out), 32'(maps[idx6_antes]));

        // Reset in the middle of a rotation
        sel = 3'd4; carregar = 1'b1; modo = 1'b1;
        ciclo();
        carregar = 1'b0;
        ciclos(2);
        verifica("mid_idx4", 32'(if8.indice), 32'(4));
        reset = 1'b1;
        ciclo();
        verifica("mid_rst_idx", 32'(if8.indice), 32'(0));
        verifica("mid_rst_out", 32'(if8.out), 32'(0));
        verifica("mid_rst_virou", 32'(if8.virou), 32'(0));
        verifica("mid_rst_estado", 32'(if8.estado), 32'(0));
        reset = 1'b0;
        ciclo();
        verifica("mid_auto", 32'(if8.estado), 32'(1));
        ciclos(3);
        verifica("mid_hold", 32'(if8.indice), 32'(0));
        ciclo();
        verifica("mid_adv", 32'(if8.indice), 32'(1));

        // Randomised phase
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) < 2);
            carregar = ($urandom_range(0, 99) < 12);
            sel      = 3'($urandom_range(0, 7));
            pausa    = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 99) < 6) modo = ~modo;
            if ($urandom_range(0, 99) < 10) maps[$urandom_range(0, 7)] = L'($urandom);
            ciclo();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
